// File: rtl/ghost_motion_ctrl.sv
// ghost_motion_ctrl
//   Moves N_GHOST ghost sprites on a divided movement tick. A global SCATTER/CHASE/FRIGHT
//   mode FSM runs on tick-counting timers. Pacman/ghost collisions are detected with one
//   cycle of latency.
// Ports
//   clk, clrn        clock, synchronous active-low reset
//   en               1 = run; 0 = freeze divider, mode timers and motion
//   pac_x, pac_y     pacman position
//   power            1-cycle pulse: power pellet eaten
//   init_x, init_y   per-ghost home position, ghost i at [i*W +: W]
//   ghost_x, ghost_y per-ghost current position, same packing
//   mode             0 SCATTER, 1 CHASE, 2 FRIGHT
//   hit, hit_id      non-frightened catch pulse and index of the lowest overlapping ghost
//   eaten            per-ghost pulse when caught while frightened
module ghost_motion_ctrl #(
    parameter int unsigned N_GHOST       = 4,
    parameter int unsigned X_W           = 10,
    parameter int unsigned Y_W           = 9,
    parameter int unsigned TICK_DIV      = 500000,
    parameter int unsigned STEP          = 1,
    parameter int unsigned X_MIN         = 8,
    parameter int unsigned X_MAX         = 631,
    parameter int unsigned Y_MIN         = 8,
    parameter int unsigned Y_MAX         = 471,
    parameter int unsigned HIT_R         = 8,
    parameter int unsigned SCATTER_TICKS = 420,
    parameter int unsigned CHASE_TICKS   = 1200,
    parameter int unsigned FRIGHT_TICKS  = 360
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     en,
    input  logic [X_W-1:0]           pac_x,
    input  logic [Y_W-1:0]           pac_y,
    input  logic                     power,
    input  logic [N_GHOST*X_W-1:0]   init_x,
    input  logic [N_GHOST*Y_W-1:0]   init_y,
    output logic [N_GHOST*X_W-1:0]   ghost_x,
    output logic [N_GHOST*Y_W-1:0]   ghost_y,
    output logic [1:0]               mode,
    output logic                     hit,
    output logic [2:0]               hit_id,
    output logic [N_GHOST-1:0]       eaten
);

    localparam int unsigned TMAX = (SCATTER_TICKS > CHASE_TICKS) ?
        ((SCATTER_TICKS > FRIGHT_TICKS) ? SCATTER_TICKS : FRIGHT_TICKS) :
        ((CHASE_TICKS > FRIGHT_TICKS) ? CHASE_TICKS : FRIGHT_TICKS);
    localparam int unsigned TW = $clog2(TMAX + 1);
    localparam int unsigned DW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {StScatter = 2'd0, StChase = 2'd1, StFright = 2'd2} mode_e;
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One STEP toward t; lands exactly on t when closer than STEP.
    function automatic int step_to(input int g, input int t);
        if (t - g >= int'(STEP)) return g + int'(STEP);
        if (g - t >= int'(STEP)) return g - int'(STEP);
        return t;
    endfunction

    // One STEP away from p, clamped to the playfield.
    function automatic int step_away(input int g, input int p, input int lo, input int hi);
        return clampi((p > g) ? g - int'(STEP) : g + int'(STEP), lo, hi);
    endfunction

    function automatic pos_t next_pos(input int idx, input pos_t g, input mode_e m,
                                      input int px, input int py);
        int   gx, gy, tx, ty, dx, dy, nx, ny;
        pos_t r;
        gx = int'(g.x);
        gy = int'(g.y);
        nx = gx;
        ny = gy;
        if (m == StFright) begin
            dx = px - gx;
            dy = py - gy;
            // Fall back to the other axis when the chosen one is pinned at the wall.
            if (iabs(dx) >= iabs(dy)) begin
                nx = step_away(gx, px, int'(X_MIN), int'(X_MAX));
                if (nx == gx) ny = step_away(gy, py, int'(Y_MIN), int'(Y_MAX));
            end else begin
                ny = step_away(gy, py, int'(Y_MIN), int'(Y_MAX));
                if (ny == gy) nx = step_away(gx, px, int'(X_MIN), int'(X_MAX));
            end
        end else begin
            if (m == StChase) begin
                tx = px;
                ty = py;
            end else begin
                tx = (idx % 4 == 1 || idx % 4 == 3) ? int'(X_MAX) : int'(X_MIN);
                ty = (idx % 4 >= 2) ? int'(Y_MAX) : int'(Y_MIN);
            end
            dx = tx - gx;
            dy = ty - gy;
            if (dx != 0 || dy != 0) begin
                if (iabs(dx) >= iabs(dy)) nx = step_to(gx, tx);
                else                      ny = step_to(gy, ty);
            end
            nx = clampi(nx, int'(X_MIN), int'(X_MAX));
            ny = clampi(ny, int'(Y_MIN), int'(Y_MAX));
        end
        r.x = X_W'(nx);
        r.y = Y_W'(ny);
        return r;
    endfunction

    logic [DW-1:0]      div_q, div_d;
    logic               tick;
    mode_e              mode_q, mode_d, saved_q, saved_d;
    logic [TW-1:0]      timer_q, timer_d;
    pos_t               pos_q  [N_GHOST];
    pos_t               pos_mv [N_GHOST];
    logic [N_GHOST-1:0] overlap, eaten_d, eaten_q;
    logic               ovl_any_q, hit_d, hit_q;
    logic [2:0]         lowest, hit_id_d, hit_id_q;

    always_comb begin
        tick  = en && (div_q == DW'(TICK_DIV - 1));
        div_d = div_q;
        if (en) div_d = tick ? '0 : div_q + 1'b1;
    end

    always_comb begin
        mode_d  = mode_q;
        saved_d = saved_q;
        timer_d = timer_q;
        if (tick) begin
            case (mode_q)
                StScatter: begin
                    if (timer_q == TW'(SCATTER_TICKS - 1)) begin
                        mode_d  = StChase;
                        timer_d = '0;
                    end else timer_d = timer_q + 1'b1;
                end
                StChase: begin
                    if (timer_q == TW'(CHASE_TICKS - 1)) begin
                        mode_d  = StScatter;
                        timer_d = '0;
                    end else timer_d = timer_q + 1'b1;
                end
                StFright: begin
                    if (timer_q == TW'(FRIGHT_TICKS - 1)) begin
                        mode_d  = saved_q;
                        timer_d = '0;
                    end else timer_d = timer_q + 1'b1;
                end
                default: begin
                    mode_d  = StScatter;
                    timer_d = '0;
                end
            endcase
        end
        // Power overrides any tick-driven transition in the same cycle.
        if (power) begin
            mode_d  = StFright;
            timer_d = '0;
            if (mode_q != StFright) saved_d = mode_q;
        end
    end

    always_comb begin
        for (int i = 0; i < N_GHOST; i++) begin
            pos_mv[i] = next_pos(i, pos_q[i], mode_q, int'(pac_x), int'(pac_y));
        end
    end

    always_comb begin
        overlap  = '0;
        eaten_d  = '0;
        lowest   = '0;
        hit_id_d = hit_id_q;
        for (int i = 0; i < N_GHOST; i++) begin
            overlap[i] = (iabs(int'(pos_q[i].x) - int'(pac_x)) < int'(HIT_R)) &&
                         (iabs(int'(pos_q[i].y) - int'(pac_y)) < int'(HIT_R));
        end
        for (int i = N_GHOST - 1; i >= 0; i--) begin
            if (overlap[i]) lowest = 3'(i);
        end
        hit_d = (mode_q != StFright) && (|overlap) && !ovl_any_q;
        if (hit_d) hit_id_d = lowest;
        for (int i = 0; i < N_GHOST; i++) begin
            eaten_d[i] = (mode_q == StFright) && overlap[i] && !eaten_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            div_q     <= '0;
            mode_q    <= StScatter;
            saved_q   <= StScatter;
            timer_q   <= '0;
            hit_q     <= 1'b0;
            hit_id_q  <= '0;
            eaten_q   <= '0;
            ovl_any_q <= 1'b0;
            for (int i = 0; i < N_GHOST; i++) begin
                pos_q[i] <= {init_x[i*X_W +: X_W], init_y[i*Y_W +: Y_W]};
            end
        end else begin
            div_q     <= div_d;
            mode_q    <= mode_d;
            saved_q   <= saved_d;
            timer_q   <= timer_d;
            hit_q     <= hit_d;
            hit_id_q  <= hit_id_d;
            eaten_q   <= eaten_d;
            ovl_any_q <= |overlap;
            for (int i = 0; i < N_GHOST; i++) begin
                // An eaten ghost returns home even if a tick move lands this cycle.
                if (eaten_d[i])  pos_q[i] <= {init_x[i*X_W +: X_W], init_y[i*Y_W +: Y_W]};
                else if (tick)   pos_q[i] <= pos_mv[i];
            end
        end
    end

    always_comb begin
        ghost_x = '0;
        ghost_y = '0;
        for (int i = 0; i < N_GHOST; i++) begin
            ghost_x[i*X_W +: X_W] = pos_q[i].x;
            ghost_y[i*Y_W +: Y_W] = pos_q[i].y;
        end
    end

    assign mode   = mode_q;
    assign hit    = hit_q;
    assign hit_id = hit_id_q;
    assign eaten  = eaten_q;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
// tb_ghost_motion_ctrl
//   Directed bench for ghost_motion_ctrl with a short tick divider and short mode timers.
//   Expected values are queued as each step is driven and popped when outputs are sampled
//   on the falling clock edge.
module tb_ghost_motion_ctrl;

    localparam int unsigned NG = 4;
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    logic              clk = 1'b0;
    logic              clrn, en, power;
    logic [XW-1:0]     pac_x;
    logic [YW-1:0]     pac_y;
    logic [NG*XW-1:0]  init_x, ghost_x;
    logic [NG*YW-1:0]  init_y, ghost_y;
    logic [1:0]        mode;
    logic              hit;
    logic [2:0]        hit_id;
    logic [NG-1:0]     eaten;

    int total = 0;
    int bad   = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    always #5 clk = ~clk;

    ghost_motion_ctrl #(
        .N_GHOST      (NG),
        .X_W          (XW),
        .Y_W          (YW),
        .TICK_DIV     (4),
        .SCATTER_TICKS(3),
        .CHASE_TICKS  (5),
        .FRIGHT_TICKS (2)
    ) dut (
        .clk    (clk),
        .clrn   (clrn),
        .en     (en),
        .pac_x  (pac_x),
        .pac_y  (pac_y),
        .power  (power),
        .init_x (init_x),
        .init_y (init_y),
        .ghost_x(ghost_x),
        .ghost_y(ghost_y),
        .mode   (mode),
        .hit    (hit),
        .hit_id (hit_id),
        .eaten  (eaten)
    );

    function automatic logic [31:0] gx(input int i);
        return 32'(ghost_x[i*XW +: XW]);
    endfunction

    function automatic logic [31:0] gy(input int i);
        return 32'(ghost_y[i*YW +: YW]);
    endfunction

    task automatic set_home(input int i, input int x, input int y);
        init_x[i*XW +: XW] = XW'(x);
        init_y[i*YW +: YW] = YW'(y);
    endtask

    task automatic set_pac(input int x, input int y);
        pac_x = XW'(x);
        pac_y = YW'(y);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (val_q.size() == 0) begin
            bad++;
            $error("FAIL sb_underflow got=%0d want=<queued value>", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s got=%0d want=%0d", t, obs, e);
            end
        end
    endtask

    initial begin
        set_home(0, 100, 50);
        set_home(1, 200, 100);
        set_home(2, 300, 8);
        set_home(3, 8, 200);
        set_pac(600, 400);
        clrn  = 1'b0;
        en    = 1'b0;
        power = 1'b0;

        // Reset state
        sb_push("rst_g0x", 100); sb_push("rst_g0y", 50); sb_push("rst_mode", 0);
        sb_push("rst_hit", 0);   sb_push("rst_eaten", 0);
        wait_n(2);
        sb_check(gx(0)); sb_check(gy(0)); sb_check(32'(mode));
        sb_check(32'(hit)); sb_check(32'(eaten));

        // Scatter: ghost0 heads for corner (8,8); fourth enabled edge is the first tick
        clrn = 1'b1;
        en   = 1'b1;
        sb_push("sc_g0x_pre", 100);
        wait_n(3);
        sb_check(gx(0));
        sb_push("sc_g0x_t1", 99); sb_push("sc_mode_t1", 0);
        wait_n(1);
        sb_check(gx(0)); sb_check(32'(mode));
        sb_push("sc_g0x_t2", 98); sb_push("sc_mode_t2", 0);
        wait_n(7);
        sb_check(gx(0)); sb_check(32'(mode));
        sb_push("sc_g0x_t3", 97); sb_push("sc_mode_chase", 1);
        sb_push("sc_g1x", 203);   sb_push("sc_g1y", 100);
        wait_n(1);
        sb_check(gx(0)); sb_check(32'(mode)); sb_check(gx(1)); sb_check(gy(1));

        // Chase: ghost1 (203,100) toward pac (221,115); tie at |dx|=|dy|=15 moves x
        set_pac(221, 115);
        sb_push("ch_g1x_t3", 206); sb_push("ch_g1y_t3", 100);
        wait_n(12);
        sb_check(gx(1)); sb_check(gy(1));
        sb_push("ch_g1x_tie", 207); sb_push("ch_g1y_tie", 100);
        wait_n(4);
        sb_check(gx(1)); sb_check(gy(1));
        sb_push("ch_mode_last", 1);
        wait_n(3);
        sb_check(32'(mode));
        sb_push("ch_g1x_t5", 207); sb_push("ch_g1y_t5", 101); sb_push("ch_mode_back", 0);
        wait_n(1);
        sb_check(gx(1)); sb_check(gy(1)); sb_check(32'(mode));

        // Frighten: ghost2 (300,8) flees pac (310,8); power inside FRIGHT restarts timer
        clrn = 1'b0;
        en   = 1'b0;
        set_pac(310, 8);
        sb_push("fr_rst_mode", 0); sb_push("fr_rst_g2x", 300);
        wait_n(2);
        sb_check(32'(mode)); sb_check(gx(2));
        clrn  = 1'b1;
        en    = 1'b1;
        power = 1'b1;
        sb_push("fr_mode_enter", 2);
        wait_n(1);
        power = 1'b0;
        sb_check(32'(mode));
        sb_push("fr_g2x_t1", 299); sb_push("fr_mode_t1", 2);
        wait_n(3);
        sb_check(gx(2)); sb_check(32'(mode));
        power = 1'b1;
        sb_push("fr_mode_repower", 2);
        wait_n(1);
        power = 1'b0;
        sb_check(32'(mode));
        sb_push("fr_g2x_t2", 298); sb_push("fr_mode_t2", 2);
        wait_n(3);
        sb_check(gx(2)); sb_check(32'(mode));
        sb_push("fr_g2x_t3", 297); sb_push("fr_mode_exit", 0); sb_push("fr_g2y", 8);
        wait_n(4);
        sb_check(gx(2)); sb_check(32'(mode)); sb_check(gy(2));

        // Clamp: ghost3 pinned at x=8 flees on y instead; then reset mid-FRIGHT
        clrn = 1'b0;
        en   = 1'b0;
        set_pac(20, 199);
        sb_push("cl_rst_g2x", 300);
        wait_n(2);
        sb_check(gx(2));
        clrn  = 1'b1;
        en    = 1'b1;
        power = 1'b1;
        sb_push("cl_mode", 2);
        wait_n(1);
        power = 1'b0;
        sb_check(32'(mode));
        sb_push("cl_g3x_t1", 8); sb_push("cl_g3y_t1", 201);
        wait_n(3);
        sb_check(gx(3)); sb_check(gy(3));
        clrn = 1'b0;
        sb_push("cl_rst_mode", 0); sb_push("cl_rst_g3y", 200);
        sb_push("cl_rst_hit", 0);  sb_push("cl_rst_eaten", 0);
        wait_n(1);
        sb_check(32'(mode)); sb_check(gy(3)); sb_check(32'(hit)); sb_check(32'(eaten));

        // Collision: hit in SCATTER, freeze with en=0, then eaten in FRIGHT
        set_pac(600, 400);
        wait_n(1);
        clrn = 1'b1;
        en   = 1'b1;
        sb_push("co_g0x_t1", 99);
        wait_n(4);
        sb_check(gx(0));
        en = 1'b0;
        set_pac(92, 50);
        sb_push("co_hit", 1); sb_push("co_hit_id", 0);
        wait_n(1);
        sb_check(32'(hit)); sb_check(32'(hit_id));
        sb_push("co_hit_held", 0);
        wait_n(1);
        sb_check(32'(hit));
        sb_push("co_frz_g0x", 99); sb_push("co_frz_hit", 0);
        wait_n(3);
        sb_check(gx(0)); sb_check(32'(hit));
        power = 1'b1;
        sb_push("co_fr_mode", 2); sb_push("co_eaten_early", 0);
        wait_n(1);
        power = 1'b0;
        sb_check(32'(mode)); sb_check(32'(eaten));
        sb_push("co_eaten", 1); sb_push("co_home_g0x", 100); sb_push("co_home_g0y", 50);
        wait_n(1);
        sb_check(32'(eaten)); sb_check(gx(0)); sb_check(gy(0));
        sb_push("co_eaten_once", 0); sb_push("co_home_hit", 0); sb_push("co_hold_g0x", 100);
        wait_n(1);
        sb_check(32'(eaten)); sb_check(32'(hit)); sb_check(gx(0));

        // Lowest-index hit_id, no re-hit while any overlap persists
        clrn = 1'b0;
        set_home(2, 204, 100);
        set_pac(210, 100);
        sb_push("id_rst_hit", 0);
        wait_n(2);
        sb_check(32'(hit));
        clrn = 1'b1;
        sb_push("id_hit", 1); sb_push("id_first", 2);
        wait_n(1);
        sb_check(32'(hit)); sb_check(32'(hit_id));
        set_pac(202, 100);
        sb_push("id_both_hit", 0); sb_push("id_both_keep", 2);
        wait_n(1);
        sb_check(32'(hit)); sb_check(32'(hit_id));
        set_pac(600, 400);
        sb_push("id_clear", 0);
        wait_n(1);
        sb_check(32'(hit));
        set_pac(202, 100);
        sb_push("id_hit2", 1); sb_push("id_lowest", 1);
        wait_n(1);
        sb_check(32'(hit)); sb_check(32'(hit_id));

        total++;
        assert (val_q.size() == 0) else begin
            bad++;
            $error("FAIL sb_leftover got=%0d want=0", val_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
